// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and ALUCtl opcode values.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    // ALUCtl operation codes; any code not listed here yields a zero result.
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_SUB  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_NOR  = 4'd12
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational MIPS ALU datapath: result and signed overflow for one operation.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUCtl,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [4:0]       w_shamt;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_slt;
    logic             w_sltu;

    assign w_sum   = A + B;
    assign w_diff  = A - B;
    assign w_shamt = A[4:0];

    // Same-sign operands producing an opposite-sign sum; for subtraction B's sign is inverted.
    assign w_add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1]  != A[WIDTH-1]);
    assign w_sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

    // Real signed compare, so SLT stays right even when A-B overflows.
    assign w_slt  = $signed(A) < $signed(B);
    assign w_sltu = A < B;

    // Operation select; unlisted codes fall through to zero with no overflow.
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (ALUCtl)
            ALU_AND:  o_result = A & B;
            ALU_OR:   o_result = A | B;
            ALU_ADD:  begin
                o_result   = w_sum;
                o_overflow = w_add_ovf;
            end
            ALU_XOR:  o_result = A ^ B;
            ALU_SLL:  o_result = B << w_shamt;
            ALU_SRL:  o_result = B >> w_shamt;
            ALU_SUB:  begin
                o_result   = w_diff;
                o_overflow = w_sub_ovf;
            end
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_sltu};
            ALU_SRA:  o_result = $unsigned($signed(B) >>> w_shamt);
            ALU_NOR:  o_result = ~(A | B);
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS ALU: one-cycle latency, accepts an operation every cycle.
module mips_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic             Zero,
    output logic             Overflow,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    logic [WIDTH-1:0] r_alu_out;
    logic             r_overflow;
    logic             r_out_valid;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .A          (A),
        .B          (B),
        .ALUCtl     (ALUCtl),
        .o_result   (w_result),
        .o_overflow (w_overflow)
    );

    // Capture result on accepted input; hold data otherwise. Reset wins over in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_out   <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_out  <= w_result;
                r_overflow <= w_overflow;
            end
        end
    end

    assign ALUOut    = r_alu_out;
    assign Overflow  = r_overflow;
    assign out_valid = r_out_valid;
    // Derived from the registered result so it can never disagree with ALUOut.
    assign Zero      = (r_alu_out == '0);

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed corner cases plus random ops vs a reference model.
module tb_mips_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  ALUCtl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUOut;
    logic        Zero;
    logic        Overflow;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_out = '0;
    logic        exp_ovf = 1'b0;
    logic        exp_vld = 1'b0;

    mips_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ALUCtl    (ALUCtl),
        .A         (A),
        .B         (B),
        .ALUOut    (ALUOut),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference model from the operation definitions, using wide signed arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        int     sh = int'(a[4:0]);
        logic [31:0] fill;
        r = '0;
        o = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = s[31:0]; o = (s != longint'(int'(s))); end
            4'd3:  r = a ^ b;
            4'd4:  r = b << sh;
            4'd5:  r = b >> sh;
            4'd6:  begin s = sa - sb; r = s[31:0]; o = (s != longint'(int'(s))); end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd9:  begin
                fill = 32'hFFFF_FFFF;
                r = (b >> sh) | ((b[31] && sh != 0) ? ~(fill >> sh) : 32'd0);
            end
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
    endfunction

    // Drive one cycle of inputs, update the expected state, and check all outputs.
    task automatic step(input logic rst, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] r;
        logic        o;
        @(negedge clk);
        rst_n = rst; in_valid = v; ALUCtl = op; A = a; B = b;
        if (!rst) begin
            exp_out = '0; exp_ovf = 1'b0; exp_vld = 1'b0;
        end else if (v) begin
            model(op, a, b, r, o);
            exp_out = r; exp_ovf = o; exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".out"},  ALUOut,           exp_out);
        chk({tag, ".zero"}, {31'd0, Zero},     {31'd0, exp_out == 32'd0});
        chk({tag, ".ovf"},  {31'd0, Overflow}, {31'd0, exp_ovf});
        chk({tag, ".vld"},  {31'd0, out_valid}, {31'd0, exp_vld});
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; ALUCtl = '0; A = '0; B = '0;

        step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, "reset");
        step(1'b0, 1'b1, 4'd2, 32'd7, 32'd9, "reset_busy");

        // Basic ops back-to-back with A=1, B=2.
        step(1'b1, 1'b1, 4'd0, 32'd1, 32'd2, "and12");
        chk("and12.lit", ALUOut, 32'd0);
        step(1'b1, 1'b1, 4'd1, 32'd1, 32'd2, "or12");
        chk("or12.lit", ALUOut, 32'd3);
        step(1'b1, 1'b1, 4'd2, 32'd1, 32'd2, "add12");
        step(1'b1, 1'b1, 4'd6, 32'd1, 32'd2, "sub12");
        chk("sub12.lit", ALUOut, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 4'd7, 32'd1, 32'd2, "slt12");

        // Overflow corners.
        step(1'b1, 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        chk("add_ovf.lit", {31'd0, Overflow}, 32'd1);
        step(1'b1, 1'b1, 4'd6, 32'h8000_0000, 32'd1, "sub_ovf");
        chk("sub_ovf.lit", ALUOut, 32'h7FFF_FFFF);
        step(1'b1, 1'b1, 4'd2, 32'hFFFF_FFFF, 32'd1, "add_wrap");

        // Signed vs unsigned compares.
        step(1'b1, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        step(1'b1, 1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1, "sltu_big");
        step(1'b1, 1'b1, 4'd7, 32'h8000_0000, 32'h7FFF_FFFF, "slt_ovf");
        chk("slt_ovf.lit", ALUOut, 32'd1);

        // Shifts.
        step(1'b1, 1'b1, 4'd4, 32'd4, 32'h8000_0000, "sll4");
        step(1'b1, 1'b1, 4'd5, 32'd4, 32'h8000_0000, "srl4");
        step(1'b1, 1'b1, 4'd9, 32'd4, 32'h8000_0000, "sra4");
        chk("sra4.lit", ALUOut, 32'hF800_0000);
        step(1'b1, 1'b1, 4'd4, 32'h20, 32'h1234_5678, "sll_wrap0");
        step(1'b1, 1'b1, 4'd9, 32'd0, 32'h8765_4321, "sra0");

        // NOR and an unlisted code.
        step(1'b1, 1'b1, 4'd12, 32'd0, 32'd0, "nor0");
        step(1'b1, 1'b1, 4'd15, 32'h1234, 32'h5678, "op15");

        // Reset beats a concurrent operation; idle cycles hold data.
        step(1'b1, 1'b1, 4'd2, 32'd5, 32'd6, "pre_rst");
        step(1'b0, 1'b1, 4'd2, 32'd1, 32'd2, "rst_vs_add");
        step(1'b1, 1'b1, 4'd3, 32'hF0F0_0000, 32'h0FF0_1234, "xor");
        step(1'b1, 1'b0, 4'd2, 32'd1, 32'd1, "hold");
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, "hold2");

        // Random traffic, operands biased toward sign/boundary values.
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = {ra[31], 31'h7FFF_FFFF ^ {31{ra[0]}}};
                1: rb = {rb[31], 31'h7FFF_FFFF ^ {31{rb[0]}}};
                2: ra = {27'd0, ra[4:0]};
                default: ;
            endcase
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)), ra, rb, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
